// File: rtl/uart_tx_fifo.sv
// UART transmit holding FIFO with first-word-fall-through head output.
// Registered empty/full/half/level status and sticky over/underflow flags.
module uart_tx_fifo #(
  parameter int pDepth = 4,
  parameter int pWidth = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic              WE,
  input  logic [pWidth-1:0] DI,
  input  logic              RE,
  output logic [pWidth-1:0] DO,
  output logic              EF,
  output logic              FF,
  output logic              HF,
  output logic [pDepth:0]   Cnt,
  output logic              OVF,
  output logic              UNF
);

  localparam int lpDepth = 1 << pDepth;
  localparam logic [pDepth:0] lpFull = (pDepth+1)'(lpDepth);
  localparam logic [pDepth:0] lpHalf = (pDepth+1)'(lpDepth / 2);
  localparam logic [pDepth:0] lpOne  = (pDepth+1)'(1);

  logic [pWidth-1:0] r_mem [lpDepth];
  logic [pDepth-1:0] r_wa;
  logic [pDepth-1:0] r_ra;
  logic [pDepth:0]   r_cnt;
  logic              r_ef;
  logic              r_ff;
  logic              r_hf;
  logic              r_ovf;
  logic              r_unf;

  logic              w_flush;
  logic              w_wr;
  logic              w_rd;
  logic [pDepth:0]   w_cnt_nxt;

  assign w_flush = Rst | Clr;
  assign w_wr    = WE & (~r_ff | RE);
  assign w_rd    = RE & ~r_ef;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr & ~w_rd)
      w_cnt_nxt = r_cnt + lpOne;
    else if (w_rd & ~w_wr)
      w_cnt_nxt = r_cnt - lpOne;
  end

  // Storage has no reset; flush only moves the pointers.
  always_ff @(posedge Clk) begin
    if (w_wr & ~w_flush)
      r_mem[r_wa] <= DI;
  end

  always_ff @(posedge Clk) begin
    if (w_flush) begin
      r_wa  <= '0;
      r_ra  <= '0;
      r_cnt <= '0;
      r_ef  <= 1'b1;
      r_ff  <= 1'b0;
      r_hf  <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_wr)
        r_wa <= r_wa + 1'b1;
      if (w_rd)
        r_ra <= r_ra + 1'b1;
      r_cnt <= w_cnt_nxt;
      r_ef  <= (w_cnt_nxt == '0);
      r_ff  <= (w_cnt_nxt == lpFull);
      r_hf  <= (w_cnt_nxt >= lpHalf);
      if (WE & r_ff & ~RE)
        r_ovf <= 1'b1;
      if (RE & r_ef)
        r_unf <= 1'b1;
    end
  end

  assign DO  = r_mem[r_ra];
  assign EF  = r_ef;
  assign FF  = r_ff;
  assign HF  = r_hf;
  assign Cnt = r_cnt;
  assign OVF = r_ovf;
  assign UNF = r_unf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo against a queue-based reference.
// Directed boundary steps followed by a randomized traffic phase.
module tb_uart_tx_fifo;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Clr = 1'b0;
  logic       WE  = 1'b0;
  logic       RE  = 1'b0;
  logic [7:0] DI  = '0;
  logic [7:0] DO;
  logic       EF;
  logic       FF;
  logic       HF;
  logic [4:0] Cnt;
  logic       OVF;
  logic       UNF;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  uart_tx_fifo #(.pDepth(4), .pWidth(8)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr),
    .WE(WE), .DI(DI), .RE(RE),
    .DO(DO), .EF(EF), .FF(FF), .HF(HF),
    .Cnt(Cnt), .OVF(OVF), .UNF(UNF)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit clr,
                       input bit we, input bit re,
                       input logic [7:0] di);
    bit full;
    bit empty;
    if (rst || clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      full  = (q.size() == 16);
      empty = (q.size() == 0);
      if (we && full && !re) m_ovf = 1'b1;
      if (re && empty) m_unf = 1'b1;
      if (re && !empty) void'(q.pop_front());
      if (we && (!full || re)) q.push_back(di);
    end
  endtask

  task automatic check_all();
    chk("EF",  32'(EF),  32'(q.size() == 0));
    chk("FF",  32'(FF),  32'(q.size() == 16));
    chk("HF",  32'(HF),  32'(q.size() >= 8));
    chk("Cnt", 32'(Cnt), 32'(q.size()));
    chk("OVF", 32'(OVF), 32'(m_ovf));
    chk("UNF", 32'(UNF), 32'(m_unf));
    if (q.size() != 0)
      chk("DO", 32'(DO), 32'(q[0]));
  endtask

  task automatic step(input bit rst, input bit clr,
                      input bit we, input bit re,
                      input logic [7:0] di);
    Rst = rst;
    Clr = clr;
    WE  = we;
    RE  = re;
    DI  = di;
    @(posedge Clk);
    #1;
    model(rst, clr, we, re, di);
    Rst = 1'b0;
    Clr = 1'b0;
    WE  = 1'b0;
    RE  = 1'b0;
    check_all();
  endtask

  initial begin
    // reset and idle underflow
    step(1, 0, 0, 0, 8'h00);
    chk("rst_ef", 32'(EF), 32'd1);
    chk("rst_cnt", 32'(Cnt), 32'd0);
    step(0, 0, 0, 1, 8'h00);
    chk("idle_unf", 32'(UNF), 32'd1);
    chk("idle_cnt", 32'(Cnt), 32'd0);
    step(0, 1, 0, 0, 8'h00);

    // order and pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++)
        step(0, 0, 1, 0, 8'(i));
      chk("fill_ff", 32'(FF), 32'd1);
      chk("fill_hf", 32'(HF), 32'd1);
      chk("fill_cnt", 32'(Cnt), 32'd16);
      for (int i = 0; i < 16; i++) begin
        chk("order_do", 32'(DO), 32'(i));
        step(0, 0, 0, 1, 8'h00);
      end
      chk("drain_ef", 32'(EF), 32'd1);
    end

    // overflow
    for (int i = 0; i < 16; i++)
      step(0, 0, 1, 0, 8'(8'h20 + i));
    step(0, 0, 1, 0, 8'hA5);
    chk("ovf_set", 32'(OVF), 32'd1);
    chk("ovf_cnt", 32'(Cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_no_a5", 32'(DO != 8'hA5), 32'd1);
      step(0, 0, 0, 1, 8'h00);
    end
    step(0, 1, 0, 0, 8'h00);
    chk("clr_ovf", 32'(OVF), 32'd0);
    chk("clr_ef", 32'(EF), 32'd1);

    // simultaneous at full
    for (int i = 0; i < 16; i++)
      step(0, 0, 1, 0, 8'(8'h40 + i));
    step(0, 0, 1, 1, 8'h5A);
    chk("sim_cnt", 32'(Cnt), 32'd16);
    chk("sim_ff", 32'(FF), 32'd1);
    chk("sim_ovf", 32'(OVF), 32'd0);
    for (int i = 0; i < 15; i++)
      step(0, 0, 0, 1, 8'h00);
    chk("sim_last", 32'(DO), 32'h5A);
    step(0, 0, 0, 1, 8'h00);
    chk("sim_ef", 32'(EF), 32'd1);

    // simultaneous at empty
    step(0, 0, 1, 1, 8'h3C);
    chk("emp_unf", 32'(UNF), 32'd1);
    chk("emp_cnt", 32'(Cnt), 32'd1);
    chk("emp_do", 32'(DO), 32'h3C);
    step(0, 1, 0, 0, 8'h00);

    // half-full boundary
    for (int i = 0; i < 7; i++)
      step(0, 0, 1, 0, 8'(8'h60 + i));
    chk("hf_7", 32'(HF), 32'd0);
    step(0, 0, 1, 0, 8'h67);
    chk("hf_8", 32'(HF), 32'd1);
    step(0, 0, 0, 1, 8'h00);
    chk("hf_pop", 32'(HF), 32'd0);

    // clear discards a same-cycle write
    step(0, 1, 1, 0, 8'h77);
    chk("clr_we_cnt", 32'(Cnt), 32'd0);
    chk("clr_we_ef", 32'(EF), 32'd1);

    // random traffic with shifting write/read bias
    for (int i = 0; i < 4000; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 70 : 35;
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 149) == 0,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < 50,
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
